// File: rtl/dispatch_fifo.sv
// rtl/dispatch_fifo.sv - two-wide in-order buffer between rename/dispatch and the ALU reservation station
//
// Purpose: accepts up to two instructions per cycle from rename and presents
// the two oldest entries to the reservation station, in order.
// Optional feature macro: DISPATCH_FIFO_FLUSH_EN (adds synchronous flush port).
//
// Ports:
//   clk                     rising-edge clock
//   reset                   asynchronous active-low reset
//   valid_in_1/valid_in_2   rename lane valids (lane 1 is older)
//   instr1/instr2           rename lane payloads
//   ready_in/ready_in2      at least one / two free entries
//   valid_out_1/valid_out_2 head / head+1 entry present
//   data_out_1/data_out_2   head / head+1 payloads (combinational read)
//   ready_out_1/ready_out_2 station accepts one / two
//   count                   current occupancy
//   flush                   synchronous clear (DISPATCH_FIFO_FLUSH_EN only)

package types_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [5:0]  rd_tag;
    logic [5:0]  rs1_tag;
    logic [5:0]  rs2_tag;
    logic [31:0] imm;
  } dispatch_pipeline_data;
endpackage

module dispatch_fifo
  import types_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in_1,
  input  logic                  valid_in_2,
  input  dispatch_pipeline_data instr1,
  input  dispatch_pipeline_data instr2,
  output logic                  ready_in,
  output logic                  ready_in2,
  output logic                  valid_out_1,
  output logic                  valid_out_2,
  output dispatch_pipeline_data data_out_1,
  output dispatch_pipeline_data data_out_2,
  input  logic                  ready_out_1,
  input  logic                  ready_out_2,
`ifdef DISPATCH_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  output logic [CW-1:0]         count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_FULL_CNT = CW'(DEPTH - 2);

  dispatch_pipeline_data mem_q [DEPTH];
  dispatch_pipeline_data mem_d [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] head_p1, tail_p1;
  logic          flush_i;
  logic          enq1, enq2, deq1, deq2;
  logic [1:0]    num_enq, num_deq;

`ifdef DISPATCH_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Power-of-two depth: plain AW-bit addition gives modulo-DEPTH wrap.
  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Space flags come from registered occupancy only, so a same-cycle
  // dequeue never makes room for an enqueue.
  assign ready_in    = (count_q < FULL_CNT);
  assign ready_in2   = (count_q <= NEAR_FULL_CNT);
  assign valid_out_1 = (count_q != '0);
  assign valid_out_2 = (count_q > CW'(1));
  assign data_out_1  = mem_q[head_q];
  assign data_out_2  = mem_q[head_p1];
  assign count       = count_q;

  always_comb begin
    enq1    = valid_in_1 && ready_in && !flush_i;
    // Lane 2 rides only behind lane 1 so the pair stays in program order.
    enq2    = enq1 && valid_in_2 && ready_in2;
    deq1    = valid_out_1 && ready_out_1 && !flush_i;
    deq2    = deq1 && valid_out_2 && ready_out_2;
    num_enq = {enq2, enq1 && !enq2};
    num_deq = {deq2, deq1 && !deq2};

    mem_d = mem_q;
    if (enq1) mem_d[tail_q]  = instr1;
    if (enq2) mem_d[tail_p1] = instr2;

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + {{(AW-2){1'b0}}, num_deq};
      tail_d  = tail_q + {{(AW-2){1'b0}}, num_enq};
      count_d = count_q + {{(CW-2){1'b0}}, num_enq} - {{(CW-2){1'b0}}, num_deq};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is intentionally not reset; occupancy gates its use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_dispatch_fifo.sv
// tb/tb_dispatch_fifo.sv - self-checking bench for dispatch_fifo
module tb_dispatch_fifo;
  import types_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  valid_in_1 = 1'b0, valid_in_2 = 1'b0;
  dispatch_pipeline_data instr1 = '0, instr2 = '0;
  logic                  ready_in, ready_in2, valid_out_1, valid_out_2;
  dispatch_pipeline_data data_out_1, data_out_2;
  logic                  ready_out_1 = 1'b0, ready_out_2 = 1'b0;
  logic [CW-1:0]         count;
`ifdef DISPATCH_FIFO_FLUSH_EN
  logic                  flush = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  dispatch_pipeline_data sb[$];

  always #5 clk = ~clk;

  dispatch_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .valid_in_1(valid_in_1), .valid_in_2(valid_in_2),
    .instr1(instr1), .instr2(instr2),
    .ready_in(ready_in), .ready_in2(ready_in2),
    .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .data_out_1(data_out_1), .data_out_2(data_out_2),
    .ready_out_1(ready_out_1), .ready_out_2(ready_out_2),
`ifdef DISPATCH_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .count(count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic dispatch_pipeline_data mk(input int n);
    dispatch_pipeline_data p;
    p.opcode  = 7'(n);
    p.rd_tag  = 6'(n * 3);
    p.rs1_tag = 6'(n + 17);
    p.rs2_tag = 6'(n * 5 + 1);
    p.imm     = 32'hC0DE_0000 ^ 32'(n * 32'h0101);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the scoreboard-derived state.
  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    chk({tag, ".count"},       64'(count),       64'(n));
    chk({tag, ".valid_out_1"}, 64'(valid_out_1), 64'(n >= 1));
    chk({tag, ".valid_out_2"}, 64'(valid_out_2), 64'(n >= 2));
    chk({tag, ".ready_in"},    64'(ready_in),    64'((DEPTH - n) >= 1));
    chk({tag, ".ready_in2"},   64'(ready_in2),   64'((DEPTH - n) >= 2));
    if (n >= 1) chk({tag, ".data_out_1"}, 64'(data_out_1), 64'(sb[0]));
    if (n >= 2) chk({tag, ".data_out_2"}, 64'(data_out_2), 64'(sb[1]));
  endtask

  // One clock of stimulus: drive at negedge, check pre-edge state, then
  // update the scoreboard with what the bench predicts the edge accepted.
  task automatic step(input string tag, input logic v1, input logic v2,
                      input dispatch_pipeline_data i1, input dispatch_pipeline_data i2,
                      input logic r1, input logic r2);
    int n;
    bit a1, a2, d1, d2;
    @(negedge clk);
    valid_in_1 = v1; valid_in_2 = v2; instr1 = i1; instr2 = i2;
    ready_out_1 = r1; ready_out_2 = r2;
    check_state(tag);
    n  = sb.size();
    a1 = v1 && ((DEPTH - n) >= 1);
    a2 = a1 && v2 && ((DEPTH - n) >= 2);
    d1 = r1 && (n >= 1);
    d2 = d1 && r2 && (n >= 2);
    @(posedge clk);
    #1;
    if (d1) void'(sb.pop_front());
    if (d2) void'(sb.pop_front());
    if (a1) sb.push_back(i1);
    if (a2) sb.push_back(i2);
    valid_in_1 = 1'b0; valid_in_2 = 1'b0; ready_out_1 = 1'b0; ready_out_2 = 1'b0;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, mk(0), mk(0), 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    #2 reset = 1'b0;
    #1;
    check_state("reset_asserted");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_state("reset_release");

    // Pairs (A,B),(C,D) with station stalled, then single dequeue
    step("enq_ab", 1, 1, mk(1), mk(2), 0, 0);
    step("enq_cd", 1, 1, mk(3), mk(4), 0, 0);
    idle("hold4");
    chk("count_after_two_pairs", 64'(count), 64'(4));
    step("deq_one", 0, 0, mk(0), mk(0), 1, 0);
    chk("data_out_1_is_b", 64'(data_out_1), 64'(mk(2)));
    chk("count_after_single_deq", 64'(count), 64'(3));

    // Fill to 7, offer a pair: only lane 1 fits
    step("fill5", 1, 1, mk(5), mk(6), 0, 0);
    step("fill7", 1, 1, mk(7), mk(8), 0, 0);
    chk("ready_in2_at_7", 64'(ready_in2), 64'(0));
    step("pair_at_7", 1, 1, mk(9), mk(10), 0, 0);
    chk("count_full", 64'(count), 64'(DEPTH));
    chk("ready_in_full", 64'(ready_in), 64'(0));
    // Full: enqueue blocked even with simultaneous dequeue
    step("full_enq_deq", 1, 1, mk(11), mk(12), 1, 0);
    chk("count_after_full_deq", 64'(count), 64'(DEPTH - 1));

    // Drain two per cycle (head=2, tail=1 -> both end at 1)
    for (int k = 0; k < 4; k++) step("drain", 0, 0, mk(0), mk(0), 1, 1);
    idle("empty_ignore");
    step("empty_ready_ignored", 0, 0, mk(0), mk(0), 1, 1);

    // Advance tail and head to 7, then wrap a pair
    for (int k = 0; k < 3; k++) step("adv_fill", 1, 1, mk(20 + 2*k), mk(21 + 2*k), 0, 0);
    for (int k = 0; k < 3; k++) step("adv_drain", 0, 0, mk(0), mk(0), 1, 1);
    step("wrap_xy", 1, 1, mk(40), mk(41), 0, 0);
    chk("wrap_x_at_head", 64'(data_out_1), 64'(mk(40)));
    chk("wrap_y_at_head1", 64'(data_out_2), 64'(mk(41)));
    step("wrap_drain", 0, 0, mk(0), mk(0), 1, 1);
    chk("wrap_empty", 64'(count), 64'(0));

    // Lane 2 without lane 1 is ignored, empty and non-empty
    step("v2_only_empty", 0, 1, mk(50), mk(51), 0, 0);
    step("enq_single", 1, 0, mk(52), mk(53), 0, 0);
    step("v2_only_nonempty", 0, 1, mk(54), mk(55), 0, 0);
    chk("v2_only_count", 64'(count), 64'(1));

    // Sustained two-in/two-out
    step("tp_fill", 1, 1, mk(60), mk(61), 0, 0);
    for (int k = 0; k < 5; k++)
      step("tp", 1, 1, mk(62 + 2*k), mk(63 + 2*k), 1, 1);
    chk("tp_count_steady", 64'(count), 64'(3));

`ifdef DISPATCH_FIFO_FLUSH_EN
    // Get to 5 then flush with concurrent enqueue/dequeue
    step("pre_flush", 1, 1, mk(80), mk(81), 0, 0);
    @(negedge clk);
    check_state("flush_pre");
    valid_in_1 = 1; valid_in_2 = 1; instr1 = mk(90); instr2 = mk(91);
    ready_out_1 = 1; ready_out_2 = 1; flush = 1;
    @(posedge clk);
    #1;
    flush = 0; valid_in_1 = 0; valid_in_2 = 0; ready_out_1 = 0; ready_out_2 = 0;
    sb.delete();
    check_state("after_flush");
    step("post_flush_enq", 1, 1, mk(92), mk(93), 0, 0);
`endif

    // Mid-stream asynchronous reset: outputs clear without a clock edge
    step("pre_reset", 1, 1, mk(100), mk(101), 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    check_state("async_reset");
    @(negedge clk);
    reset = 1'b1;
    step("post_reset_enq", 1, 1, mk(110), mk(111), 0, 0);
    step("post_reset_deq", 0, 0, mk(0), mk(0), 1, 1);
    idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
